// File: rtl/gray_to_bcd_tracker.sv
// Gray-coded decimal digit decoder with a one-deep registered output stage,
// step-direction classification against the previous digit, and error counting.
module gray_to_bcd_tracker #(
  parameter bit STEP_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] g,
  input  logic       resync,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] b,
  output logic       err_range,
  output logic       err_step,
  output logic       dir_up,
  output logic       dir_dn,
  output logic       hold,
  output logic [7:0] err_cnt
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic {ST_SYNC, ST_TRACK} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   prev_q, prev_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   b_q, b_d;
  logic            err_range_q, err_range_d;
  logic            err_step_q, err_step_d;
  logic            dir_up_q, dir_up_d;
  logic            dir_dn_q, dir_dn_d;
  logic            hold_q, hold_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;

  logic            accept;
  logic [DW-1:0]   dec;
  logic            in_range;
  logic [DW-1:0]   prev_up;
  logic [DW-1:0]   prev_dn;
  state_e          cls_state;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  assign dec      = {g[3], g[3] ^ g[2], g[3] ^ g[2] ^ g[1], ^g};
  assign in_range = (dec <= DW'(9));
  assign prev_up  = (prev_q == DW'(9)) ? DW'(0) : prev_q + DW'(1);
  assign prev_dn  = (prev_q == DW'(0)) ? DW'(9) : prev_q - DW'(1);
  // A resync arriving with a sample classifies that sample as the first one.
  assign cls_state = resync ? ST_SYNC : state_q;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q;
    b_d         = b_q;
    err_range_d = err_range_q;
    err_step_d  = err_step_q;
    dir_up_d    = dir_up_q;
    dir_dn_d    = dir_dn_q;
    hold_d      = hold_q;
    err_cnt_d   = err_cnt_q;

    if (resync) begin
      state_d = ST_SYNC;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      b_d         = dec;
      err_range_d = 1'b0;
      err_step_d  = 1'b0;
      dir_up_d    = 1'b0;
      dir_dn_d    = 1'b0;
      hold_d      = 1'b0;
      if (!in_range) begin
        err_range_d = 1'b1;
        state_d     = ST_SYNC;
      end else begin
        prev_d  = dec;
        state_d = ST_TRACK;
        if (cls_state == ST_TRACK) begin
          if (dec == prev_q) begin
            hold_d = 1'b1;
          end else if (dec == prev_up) begin
            dir_up_d = 1'b1;
          end else if (dec == prev_dn) begin
            dir_dn_d = 1'b1;
          end else begin
            err_step_d = STEP_CHECK;
          end
        end
      end
      if ((err_range_d || err_step_d) && (err_cnt_q != CW'(255))) begin
        err_cnt_d = err_cnt_q + CW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      b_q         <= '0;
      err_range_q <= 1'b0;
      err_step_q  <= 1'b0;
      dir_up_q    <= 1'b0;
      dir_dn_q    <= 1'b0;
      hold_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      b_q         <= b_d;
      err_range_q <= err_range_d;
      err_step_q  <= err_step_d;
      dir_up_q    <= dir_up_d;
      dir_dn_q    <= dir_dn_d;
      hold_q      <= hold_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign b         = b_q;
  assign err_range = err_range_q;
  assign err_step  = err_step_q;
  assign dir_up    = dir_up_q;
  assign dir_dn    = dir_dn_q;
  assign hold      = hold_q;
  assign err_cnt   = err_cnt_q;

endmodule
